// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, fault causes,
// instruction width and a word-alignment helper.
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_GAP     = 2'd0,
        ST_REQUEST = 2'd1,
        ST_HOLD    = 2'd2,
        ST_FAULT   = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_BUS_ERR = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } fetch_cause_e;

    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] a);
        return {a[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_bus.sv
// Minimal read-path bus bundle between the fetch unit and instruction memory.
interface wb_bus;
    logic [31:0] addr;
    logic        we;
    logic        stb;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (output addr, output we, output stb, input ack, input err, input rdata);
    modport slave  (input addr, input we, input stb, output ack, output err, output rdata);
endinterface

// File: rtl/fetch_watchdog.sv
// Request timeout counter: counts enabled cycles and flags the last allowed one.
module fetch_watchdog #(
    parameter int unsigned Cycles = 16
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(Cycles - 1);

    logic [7:0] count;

    always_ff @(posedge clk_in) begin
        if (!reset_in || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: GAP -> REQUEST -> HOLD loop with
// redirect override, bus-error and timeout faults.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] ResetVector   = 32'h0,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic               clk_in,
    input  logic               reset_in,
    wb_bus.master              bus_master,
    input  logic               redirect_valid_in,
    input  logic [31:0]        redirect_pc_in,
    output logic               instr_valid_out,
    input  logic               instr_ready_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc_out,
    output logic               fetch_err_out,
    output logic [1:0]         fetch_err_cause_out
);

    fetch_state_e       state, state_d;
    fetch_cause_e       cause, cause_d;
    logic [31:0]        pc, pc_d;
    logic [INSTR_W-1:0] buf_instr;
    logic [31:0]        buf_pc;
    logic               capture;
    logic               expired;

    fetch_watchdog #(.Cycles(TimeoutCycles)) u_watchdog (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (state != ST_REQUEST),
        .enable   (state == ST_REQUEST),
        .expired  (expired)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state     <= ST_GAP;
            cause     <= CAUSE_NONE;
            pc        <= align_word(ResetVector);
            buf_instr <= '0;
            buf_pc    <= '0;
        end else begin
            state <= state_d;
            cause <= cause_d;
            pc    <= pc_d;
            if (capture) begin
                buf_instr <= bus_master.rdata;
                buf_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_d = state;
        cause_d = cause;
        pc_d    = pc;
        capture = 1'b0;
        unique case (state)
            ST_GAP: state_d = ST_REQUEST;
            ST_REQUEST: begin
                if (bus_master.err) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_BUS_ERR;
                end else if (bus_master.ack) begin
                    state_d = ST_HOLD;
                    capture = 1'b1;
                end else if (expired) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_HOLD: begin
                if (instr_ready_in) begin
                    pc_d    = pc + 32'd4;
                    state_d = ST_REQUEST;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_GAP;
        endcase
        // Redirect overrides everything, including a same-cycle response.
        if (redirect_valid_in) begin
            state_d = ST_GAP;
            cause_d = CAUSE_NONE;
            pc_d    = align_word(redirect_pc_in);
            capture = 1'b0;
        end
    end

    assign bus_master.addr     = align_word(pc);
    assign bus_master.we       = 1'b0;
    assign bus_master.stb      = (state == ST_REQUEST);

    assign instr_valid_out     = (state == ST_HOLD);
    assign instr_out           = buf_instr;
    assign instr_pc_out        = (state == ST_FAULT) ? pc : buf_pc;
    assign fetch_err_out       = (state == ST_FAULT);
    assign fetch_err_cause_out = cause;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency memory responder.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b1;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ferr;
    logic [1:0]  fcause;

    logic        silent = 1'b0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic        ack_r = 1'b0;
    logic        err_r = 1'b0;
    logic [31:0] rdata_r = 32'h0;

    int n_checks = 0;
    int n_fail = 0;

    wb_bus bus();

    instr_fetch #(.ResetVector(32'h0), .TimeoutCycles(4)) dut (
        .clk_in              (clk),
        .reset_in            (rst_n),
        .bus_master          (bus),
        .redirect_valid_in   (redirect_valid),
        .redirect_pc_in      (redirect_pc),
        .instr_valid_out     (valid),
        .instr_ready_in      (ready),
        .instr_out           (instr),
        .instr_pc_out        (instr_pc),
        .fetch_err_out       (ferr),
        .fetch_err_cause_out (fcause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00128293 : ~a;
    endfunction

    // Memory answers one cycle after it first sees stb; independent of DUT reset.
    always @(posedge clk) begin
        ack_r   <= bus.stb && !ack_r && !err_r && !silent && !(err_en && bus.addr == err_addr);
        err_r   <= bus.stb && !ack_r && !err_r && err_en && bus.addr == err_addr;
        rdata_r <= mem_word(bus.addr);
    end

    assign bus.ack   = ack_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_hold(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_pc"}, instr_pc, exp_pc);
        chk({tag, "_stb"}, 32'(bus.stb), 32'd0);
    endtask

    initial begin
        // reset
        tick(); tick(); tick();
        chk("rst_stb", 32'(bus.stb), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_err", 32'(ferr), 32'd0);
        chk("rst_cause", 32'(fcause), 32'd0);
        chk("rst_addr", bus.addr, 32'h0);
        rst_n = 1'b1;
        tick();                                   // cycle 2 after release
        chk("first_stb", 32'(bus.stb), 32'd1);
        chk("first_addr", bus.addr, 32'h0);
        chk("we_low", 32'(bus.we), 32'd0);
        tick();
        chk("first_ack", 32'(bus.ack), 32'd1);
        tick();
        chk_idle_hold("hold0", 32'h00128293, 32'h0);
        tick();
        chk("next_stb", 32'(bus.stb), 32'd1);
        chk("next_addr", bus.addr, 32'h4);
        chk("next_valid", 32'(valid), 32'd0);
        tick(); tick();
        chk_idle_hold("hold4", 32'hFFFFFFFB, 32'h4);

        // decode stalls for 5 cycles
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle_hold("stall", 32'hFFFFFFFB, 32'h4);
        end
        ready = 1'b1;
        tick();
        chk("after_stall_valid", 32'(valid), 32'd0);
        chk("after_stall_addr", bus.addr, 32'h8);
        chk("after_stall_stb", 32'(bus.stb), 32'd1);

        // bus error at 0x8
        err_en = 1'b1; err_addr = 32'h8;
        tick();
        chk("err_seen", 32'(bus.err), 32'd1);
        tick();
        err_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("berr_err", 32'(ferr), 32'd1);
            chk("berr_cause", 32'(fcause), 32'd1);
            chk("berr_pc", instr_pc, 32'h8);
            chk("berr_valid", 32'(valid), 32'd0);
            chk("berr_stb", 32'(bus.stb), 32'd0);
            tick();
        end
        chk("berr_buf", instr, 32'hFFFFFFFB);

        // redirect out of fault, low bits ignored
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        tick();
        redirect_valid = 1'b0;
        chk("rd_err", 32'(ferr), 32'd0);
        chk("rd_cause", 32'(fcause), 32'd0);
        chk("rd_gap_stb", 32'(bus.stb), 32'd0);
        chk("rd_addr", bus.addr, 32'h20);
        tick();
        chk("rd_req_stb", 32'(bus.stb), 32'd1);
        tick();
        chk("rd_ack", 32'(bus.ack), 32'd1);

        // redirect to 0x100 together with the ack
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_valid", 32'(valid), 32'd0);
        chk("drop_stb", 32'(bus.stb), 32'd0);
        chk("drop_err", 32'(ferr), 32'd0);
        chk("drop_addr", bus.addr, 32'h100);
        tick();
        chk("drop_req_stb", 32'(bus.stb), 32'd1);
        chk("drop_req_addr", bus.addr, 32'h100);
        tick(); tick();
        chk_idle_hold("hold100", 32'hFFFFFEFF, 32'h100);

        // redirect while the handshake is accepted: no +4
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        chk("hs_rd_valid", 32'(valid), 32'd0);
        chk("hs_rd_stb", 32'(bus.stb), 32'd0);
        chk("hs_rd_addr", bus.addr, 32'hFFFFFFFC);
        tick(); tick(); tick();
        chk_idle_hold("holdtop", 32'h00000003, 32'hFFFFFFFC);
        tick();
        chk("wrap_stb", 32'(bus.stb), 32'd1);
        chk("wrap_addr", bus.addr, 32'h0);
        tick(); tick();
        chk_idle_hold("holdwrap", 32'h00128293, 32'h0);

        // silent slave: timeout after 4 request cycles
        silent = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_stb", 32'(bus.stb), 32'd1);
            chk("to_noerr", 32'(ferr), 32'd0);
        end
        tick();
        chk("to_err", 32'(ferr), 32'd1);
        chk("to_cause", 32'(fcause), 32'd2);
        chk("to_pc", instr_pc, 32'h4);
        chk("to_stb_low", 32'(bus.stb), 32'd0);
        silent = 1'b0;

        // reset in the middle of a request; the late ack must be ignored
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("mid_stb", 32'(bus.stb), 32'd1);
        chk("mid_addr", bus.addr, 32'h40);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_stb", 32'(bus.stb), 32'd0);
        chk("mid_rst_addr", bus.addr, 32'h0);
        chk("mid_rst_err", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_stb", 32'(bus.stb), 32'd1);
        chk("post_rst_valid", 32'(valid), 32'd0);
        chk("post_rst_addr", bus.addr, 32'h0);
        tick(); tick();
        chk_idle_hold("post_rst_hold", 32'h00128293, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ResetVector, default 32'h0: word-aligned fetch address after reset.
REQ-002 Parameter TimeoutCycles, default 16: maximum REQUEST cycles without ack before fault (range 2..255).
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  reset, synchronous, active-low.
REQ-005 bus_master  wb_bus.master  -  addr[31:0], we, stb out; ack, err, rdata[31:0] in.
REQ-006 redirect_valid_in  input  1  PC redirect request from execute.
REQ-007 redirect_pc_in  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-008 instr_valid_out  output  1  instr_out and instr_pc_out hold a valid instruction.
REQ-009 instr_ready_in  input  1  decode accepts the instruction this cycle.
REQ-010 instr_out  output  32  fetched instruction word.
REQ-011 instr_pc_out  output  32  address of instr_out.
REQ-012 fetch_err_out  output  1  fetch unit halted in FAULT.
REQ-013 fetch_err_cause_out  output  2  0 none, 1 bus err, 2 timeout.

Function
REQ-014 States: GAP, REQUEST, HOLD, FAULT; bus_master.stb = 1 only in REQUEST.
REQ-015 bus_master.we SHALL be 0 always; addr = {pc[31:2], 2'b00} in every cycle.
REQ-016 GAP: stb=0 for exactly one cycle, then REQUEST.
REQ-017 REQUEST, ack=1 and err=0: capture rdata and pc into output buffer; next state HOLD.
REQ-018 REQUEST, err=1 (priority over ack): next state FAULT, cause 1, buffer unchanged.
REQ-019 REQUEST, timeout counter reaching TimeoutCycles-1 without ack/err: next state FAULT, cause 2.
REQ-020 Timeout counter clears on every entry to REQUEST and increments each REQUEST cycle.
REQ-021 HOLD: instr_valid_out=1; on instr_valid_out & instr_ready_in, pc <= pc+4 (mod 2^32, wraps) and next state REQUEST.
REQ-022 HOLD lasts at least one cycle, guaranteeing stb low between consecutive requests; no duplicate ack is consumed.
REQ-023 Redirect in any state has priority: pc <= redirect target, buffer invalidated, cause cleared, next state GAP.
REQ-024 Redirect in the same cycle as ack or err: the response is discarded, no fault recorded.
REQ-025 Redirect in the same cycle as an accepted HOLD handshake: the handshake completes and redirect sets pc (no +4).
REQ-026 FAULT: stb=0, instr_valid_out=0, fetch_err_out=1, instr_pc_out = faulting pc; exit only via redirect.
REQ-027 Steady-state throughput with ready held high: one instruction per 3 cycles (REQUEST, ack, HOLD).

Reset
REQ-028 While reset_in=0: state GAP, pc=ResetVector, stb=0, instr_valid_out=0, instr_out=0, instr_pc_out=0, fetch_err_out=0, cause=0, timeout counter=0.
REQ-029 First stb asserted in the second cycle after reset_in rises.
REQ-030 Reset mid-request aborts the request; any ack arriving after reset is ignored.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum, the 2-bit cause enum, and the instruction width constant.
REQ-032 Timeout counter SHALL be a sub-module fetch_watchdog (clear, enable, expired).

Verification
REQ-033 Reset release, ResetVector=0, memory word 0 = 32'h00128293, ready=1 -> stb in cycle 2, valid with instr=32'h00128293, pc=0; next addr 4.
REQ-034 ready held 0 for 5 cycles in HOLD -> instr/pc stable, stb=0 throughout; single transfer when ready rises.
REQ-035 Redirect to 32'h100 in the same cycle as ack -> response dropped, one GAP cycle, next stb addr=32'h100.
REQ-036 Slave asserts err on request at 32'h8 -> FAULT, fetch_err_out=1, cause=1, instr_pc_out=32'h8; stays until redirect.
REQ-037 Slave never acks, TimeoutCycles=4 -> FAULT after 4 REQUEST cycles, cause=2.
REQ-038 pc=32'hFFFFFFFC accepted -> next fetch addr 32'h0.
